// File: rtl/dm_bus_bridge_if.sv
// Request/response bus between the data-memory bridge (master) and a slave.
interface dm_bus_bridge_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_error;

  modport master (
    output bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_error
  );

  modport slave (
    input  bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_error
  );
endinterface

// File: rtl/dm_bus_bridge.sv
// Turns the CPU's single-cycle SRAM-style data-memory access into a
// valid/ready request plus single-pulse response, stalling the pipeline
// until completion. A response timeout and sticky error capture keep a
// broken slave from deadlocking the core.
module dm_bus_bridge #(
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_cs,
  input  logic        DM_OE,
  input  logic [3:0]  DM_WEB,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_DI,
  output logic [31:0] DM_DO,
  output logic        cpu_stall,
  dm_bus_bridge_if.master bus,
  output logic        err_flag,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_stall;
  logic        w_req_valid;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_dm_do;
  logic        r_err_flag;
  logic [31:0] r_err_addr;
  logic [CW-1:0] r_cnt;

  logic        w_is_write;
  logic        w_acc;
  logic        w_handshake;
  logic        w_rsp_take;
  logic        w_timeout;
  logic        w_err_event;

  assign w_is_write  = (DM_WEB != 4'hF);
  assign w_acc       = DM_cs & (DM_OE | w_is_write);
  assign w_handshake = (r_state == S_REQ) & bus.bus_req_ready;
  // A response in the handshake cycle never reaches here: only WAIT_RSP listens.
  assign w_rsp_take  = (r_state == S_WAIT_RSP) & bus.bus_rsp_valid;
  // A response landing on the last counted cycle beats the timeout.
  assign w_timeout   = (r_state == S_WAIT_RSP) & ~bus.bus_rsp_valid & (r_cnt == CNT_LAST);
  assign w_err_event = (w_rsp_take & bus.bus_rsp_error) | w_timeout;

  // State register; async reset drops the transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode plus the combinational stall and request-valid outputs.
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_req_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_acc;
        if (w_acc) w_state_next = S_REQ;
      end
      S_REQ: begin
        w_stall     = 1'b1;
        w_req_valid = 1'b1;
        if (bus.bus_req_ready) w_state_next = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        w_stall = 1'b1;
        if (w_rsp_take || w_timeout) w_state_next = S_DONE;
      end
      S_DONE: begin
        // One stall-free cycle lets MEMWB capture DM_DO; inputs are not re-sampled.
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request fields are captured once in IDLE and held until the next access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'h0;
    end else if (r_state == S_IDLE && w_acc) begin
      r_write <= w_is_write;
      r_addr  <= {DM_addr[31:2], 2'b00};
      r_wdata <= DM_DI;
      r_wstrb <= ~DM_WEB;
    end
  end

  // Response-wait counter: cleared at the handshake, counts WAIT_RSP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (w_handshake)           r_cnt <= '0;
    else if (r_state == S_WAIT_RSP) r_cnt <= r_cnt + 1'b1;
  end

  // Read data returned to the CPU; writes leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_dm_do <= 32'h0;
    else if (w_rsp_take && !r_write) r_dm_do <= bus.bus_rsp_rdata;
    else if (w_timeout && !r_write)  r_dm_do <= TIMEOUT_RDATA;
  end

  // Sticky error record; a clear wins over a coincident new error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_flag <= 1'b0;
      r_err_addr <= 32'h0;
    end else if (err_clr) begin
      r_err_flag <= 1'b0;
      r_err_addr <= 32'h0;
    end else if (w_err_event) begin
      r_err_flag <= 1'b1;
      if (!r_err_flag) r_err_addr <= r_addr;
    end
  end

  assign cpu_stall         = w_stall;
  assign DM_DO             = r_dm_do;
  assign err_flag          = r_err_flag;
  assign err_addr          = r_err_addr;
  assign bus.bus_req_valid = w_req_valid;
  assign bus.bus_req_write = r_write;
  assign bus.bus_req_addr  = r_addr;
  assign bus.bus_req_wdata = r_wdata;
  assign bus.bus_req_wstrb = r_wstrb;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Testbench for dm_bus_bridge: directed scenarios plus randomized accesses
// against a transaction-level reference model.
module tb_dm_bus_bridge;
  localparam int          TO      = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        DM_cs, DM_OE;
  logic [3:0]  DM_WEB;
  logic [31:0] DM_addr, DM_DI, DM_DO;
  logic        cpu_stall, err_flag, err_clr;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] exp_do;
  logic        exp_flag;
  logic [31:0] exp_eaddr;

  // observations from the last driven access
  int          obs_stall, obs_vcyc;
  logic [31:0] obs_addr, obs_wdata, obs_do;
  logic [3:0]  obs_wstrb;
  logic        obs_write, obs_stable, obs_dup, obs_hung;

  dm_bus_bridge_if bus_if();

  dm_bus_bridge #(.TIMEOUT(TO), .TIMEOUT_RDATA(TO_DATA)) dut (
    .clk(clk), .rst(rst), .DM_cs(DM_cs), .DM_OE(DM_OE), .DM_WEB(DM_WEB),
    .DM_addr(DM_addr), .DM_DI(DM_DI), .DM_DO(DM_DO), .cpu_stall(cpu_stall),
    .bus(bus_if), .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stall length: the IDLE cycle, every REQ cycle, then the response wait
  // (cut at TO cycles when the slave never answers in time).
  function automatic int exp_stall_f(input int rdy_dly, input int rsp_dly);
    if (rsp_dly >= 0 && rsp_dly < TO) return 1 + (rdy_dly + 1) + (rsp_dly + 1);
    return 1 + (rdy_dly + 1) + TO;
  endfunction

  task automatic model_update(input logic wr, input logic [31:0] addr, input int rsp_dly,
                              input logic [31:0] rdata, input logic rerr);
    bit timed = !(rsp_dly >= 0 && rsp_dly < TO);
    if (!wr) exp_do = timed ? TO_DATA : rdata;
    if (timed || rerr) begin
      if (!exp_flag) exp_eaddr = {addr[31:2], 2'b00};
      exp_flag = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_flag  = 1'b0;
    exp_eaddr = 32'h0;
  endtask

  // Plays one CPU access and a slave that answers ready after rdy_dly extra
  // REQ cycles and responds rsp_dly cycles after the first wait cycle
  // (rsp_dly < 0: never). Returns #1 after the edge leaving DONE.
  task automatic drive_access(input logic wr, input logic oe, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] web,
                              input int rdy_dly, input int rsp_dly,
                              input logic [31:0] rdata, input logic rerr);
    int k = 0;
    bit hs = 0;
    bit done = 0;
    DM_cs = 1'b1; DM_OE = oe; DM_WEB = wr ? web : 4'hF; DM_addr = addr; DM_DI = wdata;
    obs_stall = 0; obs_vcyc = 0; obs_stable = 1'b1; obs_dup = 1'b0; obs_do = 32'h0;
    obs_addr = 32'h0; obs_wdata = 32'h0; obs_wstrb = 4'h0; obs_write = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      bus_if.bus_req_ready = 1'b0;
      bus_if.bus_rsp_valid = 1'b0;
      bus_if.bus_rsp_error = 1'b0;
      if (hs) k++;
      if (!cpu_stall) begin
        done = 1;
        obs_do  = DM_DO;
        obs_dup = bus_if.bus_req_valid;
      end else begin
        obs_stall++;
        if (bus_if.bus_req_valid) begin
          obs_vcyc++;
          if (obs_vcyc == 1) begin
            obs_addr = bus_if.bus_req_addr; obs_wdata = bus_if.bus_req_wdata;
            obs_wstrb = bus_if.bus_req_wstrb; obs_write = bus_if.bus_req_write;
          end else if (obs_addr !== bus_if.bus_req_addr || obs_wdata !== bus_if.bus_req_wdata ||
                       obs_wstrb !== bus_if.bus_req_wstrb || obs_write !== bus_if.bus_req_write) begin
            obs_stable = 1'b0;
          end
          if (!hs && obs_vcyc == rdy_dly + 1) begin
            bus_if.bus_req_ready = 1'b1;
            hs = 1;
          end
        end
        if (hs && rsp_dly >= 0 && k == rsp_dly + 1) begin
          bus_if.bus_rsp_valid = 1'b1;
          bus_if.bus_rsp_rdata = rdata;
          bus_if.bus_rsp_error = rerr;
        end
      end
    end
    obs_hung = !done;
    @(posedge clk); #1;
    DM_cs = 1'b0; DM_OE = 1'b0; DM_WEB = 4'hF;
    bus_if.bus_req_ready = 1'b0; bus_if.bus_rsp_valid = 1'b0; bus_if.bus_rsp_error = 1'b0;
    $display("txn wr=%0d addr=%h rdy=%0d rsp=%0d stall=%0d do=%h err=%0d/%h",
             wr, addr, rdy_dly, rsp_dly, obs_stall, obs_do, err_flag, err_addr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_do = 32'h0; exp_flag = 1'b0; exp_eaddr = 32'h0;
    @(negedge clk);
    checks += 6;
    if (DM_DO !== 32'h0) begin errors++; $display("FAIL reset_do: got %h expected 0", DM_DO); end
    if (cpu_stall !== 1'b0 || bus_if.bus_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: stall %b valid %b expected 0 0", cpu_stall, bus_if.bus_req_valid);
    end
    if (bus_if.bus_req_write !== 1'b0 || bus_if.bus_req_wstrb !== 4'h0) begin
      errors++; $display("FAIL reset_wr: write %b wstrb %h expected 0 0", bus_if.bus_req_write, bus_if.bus_req_wstrb);
    end
    if (bus_if.bus_req_addr !== 32'h0 || bus_if.bus_req_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_req: addr %h wdata %h expected 0 0", bus_if.bus_req_addr, bus_if.bus_req_wdata);
    end
    if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", err_flag); end
    if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_eaddr: got %h expected 0", err_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 12; i++) begin
      DM_addr = $urandom; DM_DI = $urandom;
      if (i % 2 == 0) begin DM_cs = 1'b0; DM_OE = 1'($urandom_range(0, 1)); DM_WEB = 4'($urandom); end
      else begin DM_cs = 1'b1; DM_OE = 1'b0; DM_WEB = 4'hF; end
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b0 || bus_if.bus_req_valid !== 1'b0) begin
        errors++; $display("FAIL idle_%0d: stall %b valid %b expected 0 0", i, cpu_stall, bus_if.bus_req_valid);
      end
      @(posedge clk); #1;
    end
    DM_cs = 1'b0; DM_OE = 1'b0; DM_WEB = 4'hF;
  endtask

  task automatic test_read();
    drive_access(1'b0, 1'b1, 32'h0000_1006, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 1'b0);
    model_update(1'b0, 32'h0000_1006, 0, 32'h1234_5678, 1'b0);
    checks += 4;
    if (obs_addr !== 32'h0000_1004 || obs_write !== 1'b0) begin
      errors++; $display("FAIL read_req: addr %h write %b expected 00001004 0", obs_addr, obs_write);
    end
    if (obs_stall != 3) begin errors++; $display("FAIL read_stall: got %0d expected 3", obs_stall); end
    if (obs_do !== exp_do) begin errors++; $display("FAIL read_do: got %h expected %h", obs_do, exp_do); end
    if (obs_hung || obs_dup) begin errors++; $display("FAIL read_done: hung %b dup %b expected 0 0", obs_hung, obs_dup); end
  endtask

  task automatic test_byte_write();
    drive_access(1'b1, 1'b1, 32'h0000_0040, 32'h0000_AB00, 4'b1101, 3, 0, 32'h5555_5555, 1'b0);
    model_update(1'b1, 32'h0000_0040, 0, 32'h5555_5555, 1'b0);
    checks += 5;
    if (obs_write !== 1'b1 || obs_wstrb !== 4'b0010) begin
      errors++; $display("FAIL bw_req: write %b wstrb %b expected 1 0010", obs_write, obs_wstrb);
    end
    if (obs_wdata !== 32'h0000_AB00 || obs_addr !== 32'h0000_0040) begin
      errors++; $display("FAIL bw_fields: wdata %h addr %h expected 0000ab00 00000040", obs_wdata, obs_addr);
    end
    if (!obs_stable || obs_vcyc != 4) begin
      errors++; $display("FAIL bw_hold: stable %b valid_cycles %0d expected 1 4", obs_stable, obs_vcyc);
    end
    if (obs_do !== exp_do) begin errors++; $display("FAIL bw_do: got %h expected %h", obs_do, exp_do); end
    if (obs_stall != 6) begin errors++; $display("FAIL bw_stall: got %0d expected 6", obs_stall); end
  endtask

  task automatic test_rsp_timeout_tie();
    pulse_clr();
    drive_access(1'b0, 1'b1, 32'h0000_0500, 32'h0, 4'hF, 0, TO - 1, 32'hCAFE_0001, 1'b0);
    model_update(1'b0, 32'h0000_0500, TO - 1, 32'hCAFE_0001, 1'b0);
    checks += 3;
    if (obs_stall != exp_stall_f(0, TO - 1)) begin
      errors++; $display("FAIL tie_stall: got %0d expected %0d", obs_stall, exp_stall_f(0, TO - 1));
    end
    if (obs_do !== exp_do) begin errors++; $display("FAIL tie_do: got %h expected %h", obs_do, exp_do); end
    if (err_flag !== exp_flag) begin errors++; $display("FAIL tie_flag: got %b expected %b", err_flag, exp_flag); end
  endtask

  task automatic test_timeout();
    pulse_clr();
    drive_access(1'b0, 1'b1, 32'h0000_0777, 32'h0, 4'hF, 1, -1, 32'h0, 1'b0);
    model_update(1'b0, 32'h0000_0777, -1, 32'h0, 1'b0);
    checks += 4;
    if (obs_stall != exp_stall_f(1, -1)) begin
      errors++; $display("FAIL to_stall: got %0d expected %0d", obs_stall, exp_stall_f(1, -1));
    end
    if (obs_do !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_do: got %h expected deadbeef", obs_do); end
    if (err_flag !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", err_flag); end
    if (err_addr !== 32'h0000_0774) begin errors++; $display("FAIL to_eaddr: got %h expected 00000774", err_addr); end
  endtask

  task automatic test_error_clear();
    pulse_clr();
    drive_access(1'b0, 1'b1, 32'h0000_2000, 32'h0, 4'hF, 0, 1, 32'h0BAD_0001, 1'b1);
    model_update(1'b0, 32'h0000_2000, 1, 32'h0BAD_0001, 1'b1);
    checks += 3;
    if (err_flag !== 1'b1 || err_addr !== 32'h0000_2000) begin
      errors++; $display("FAIL err1: flag %b addr %h expected 1 00002000", err_flag, err_addr);
    end
    if (DM_DO !== exp_do) begin errors++; $display("FAIL err1_do: got %h expected %h", DM_DO, exp_do); end
    drive_access(1'b0, 1'b1, 32'h0000_3000, 32'h0, 4'hF, 2, 0, 32'h0BAD_0002, 1'b1);
    model_update(1'b0, 32'h0000_3000, 0, 32'h0BAD_0002, 1'b1);
    if (err_addr !== exp_eaddr || err_flag !== exp_flag) begin
      errors++; $display("FAIL err2_sticky: flag %b addr %h expected %b %h", err_flag, err_addr, exp_flag, exp_eaddr);
    end
    pulse_clr();
    checks++;
    if (err_flag !== 1'b0 || err_addr !== 32'h0) begin
      errors++; $display("FAIL err_clr: flag %b addr %h expected 0 0", err_flag, err_addr);
    end
  endtask

  task automatic test_reset_midflight();
    DM_cs = 1'b1; DM_OE = 1'b1; DM_WEB = 4'hF; DM_addr = 32'h0000_0900;
    @(negedge clk);                        // IDLE cycle
    @(negedge clk);                        // REQ cycle: accept
    bus_if.bus_req_ready = 1'b1;
    @(negedge clk);                        // first WAIT_RSP cycle
    bus_if.bus_req_ready = 1'b0;
    checks++;
    if (cpu_stall !== 1'b1 || bus_if.bus_req_valid !== 1'b0) begin
      errors++; $display("FAIL mf_wait: stall %b valid %b expected 1 0", cpu_stall, bus_if.bus_req_valid);
    end
    #2 rst = 1'b1; DM_cs = 1'b0; DM_OE = 1'b0;
    exp_do = 32'h0; exp_flag = 1'b0; exp_eaddr = 32'h0;
    #1;
    checks += 2;
    if (cpu_stall !== 1'b0 || bus_if.bus_req_valid !== 1'b0) begin
      errors++; $display("FAIL mf_rst: stall %b valid %b expected 0 0", cpu_stall, bus_if.bus_req_valid);
    end
    if (DM_DO !== 32'h0) begin errors++; $display("FAIL mf_rst_do: got %h expected 0", DM_DO); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'hABCD_1234; bus_if.bus_rsp_error = 1'b1;
    @(negedge clk);
    bus_if.bus_rsp_valid = 1'b0; bus_if.bus_rsp_error = 1'b0;
    checks += 2;
    if (DM_DO !== exp_do || err_flag !== exp_flag) begin
      errors++; $display("FAIL mf_late_rsp: do %h flag %b expected %h %b", DM_DO, err_flag, exp_do, exp_flag);
    end
    if (cpu_stall !== 1'b0 || bus_if.bus_req_valid !== 1'b0) begin
      errors++; $display("FAIL mf_idle: stall %b valid %b expected 0 0", cpu_stall, bus_if.bus_req_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    drive_access(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'hF, 0, 0, d0, 1'b0);
    model_update(1'b0, 32'h0000_0010, 0, d0, 1'b0);
    checks += 2;
    if (obs_do !== exp_do || obs_addr !== 32'h10) begin
      errors++; $display("FAIL b2b_0: do %h addr %h expected %h 00000010", obs_do, obs_addr, exp_do);
    end
    if (obs_vcyc != 1 || obs_dup) begin
      errors++; $display("FAIL b2b_0_hs: valid_cycles %0d dup %b expected 1 0", obs_vcyc, obs_dup);
    end
    drive_access(1'b0, 1'b1, 32'h0000_0014, 32'h0, 4'hF, 0, 0, d1, 1'b0);
    model_update(1'b0, 32'h0000_0014, 0, d1, 1'b0);
    checks += 2;
    if (obs_do !== exp_do || obs_addr !== 32'h14) begin
      errors++; $display("FAIL b2b_1: do %h addr %h expected %h 00000014", obs_do, obs_addr, exp_do);
    end
    if (obs_vcyc != 1 || obs_dup || obs_stall != 3) begin
      errors++; $display("FAIL b2b_1_hs: valid_cycles %0d dup %b stall %0d expected 1 0 3", obs_vcyc, obs_dup, obs_stall);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic        wr, oe, rerr;
      logic [3:0]  web;
      logic [31:0] addr, wdata, rdata;
      int          rdy, rsp, r;
      wr = 1'($urandom_range(0, 1)); oe = 1'($urandom_range(0, 1));
      web = wr ? 4'($urandom_range(0, 14)) : 4'hF;
      if (!wr) oe = 1'b1;
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      rdy = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      rsp = (r == 9) ? -1 : r;
      rerr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) pulse_clr();
      drive_access(wr, oe, addr, wdata, web, rdy, rsp, rdata, rerr);
      model_update(wr, addr, rsp, rdata, rerr);
      checks += 5;
      if (obs_stall != exp_stall_f(rdy, rsp) || obs_hung) begin
        errors++; $display("FAIL rnd%0d_stall: got %0d expected %0d", n, obs_stall, exp_stall_f(rdy, rsp));
      end
      if (obs_addr !== {addr[31:2], 2'b00} || obs_write !== wr) begin
        errors++; $display("FAIL rnd%0d_req: addr %h write %b expected %h %b", n, obs_addr, obs_write, {addr[31:2], 2'b00}, wr);
      end
      if (obs_wstrb !== ~web || obs_wdata !== wdata) begin
        errors++; $display("FAIL rnd%0d_wr: wstrb %h wdata %h expected %h %h", n, obs_wstrb, obs_wdata, ~web, wdata);
      end
      if (obs_do !== exp_do || !obs_stable || obs_dup || obs_vcyc != rdy + 1) begin
        errors++; $display("FAIL rnd%0d_do: do %h stable %b dup %b vcyc %0d expected %h 1 0 %0d", n, obs_do, obs_stable, obs_dup, obs_vcyc, exp_do, rdy + 1);
      end
      if (err_flag !== exp_flag || err_addr !== exp_eaddr) begin
        errors++; $display("FAIL rnd%0d_err: flag %b addr %h expected %b %h", n, err_flag, err_addr, exp_flag, exp_eaddr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    DM_cs = 1'b0; DM_OE = 1'b0; DM_WEB = 4'hF; DM_addr = 32'h0; DM_DI = 32'h0;
    bus_if.bus_req_ready = 1'b0; bus_if.bus_rsp_valid = 1'b0;
    bus_if.bus_rsp_rdata = 32'h0; bus_if.bus_rsp_error = 1'b0;
    test_reset();
    test_idle();
    test_read();
    test_byte_write();
    test_rsp_timeout_tie();
    test_timeout();
    test_error_clear();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
